// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async FIFO (rd_clk domain).
// Drains DATA_WIDTH entries through rd_en/empty/rd_data and packs PACK_RATIO
// consecutive entries into one wide word on a valid/ready output stream.
// flush (or an idle timeout) emits a partial word with a lane-valid mask.
// Optional feature macro: FIFO_PACK_TIMEOUT_EN enables the idle auto-flush
// counter. When it is undefined, partial words are held until flush.

// One accumulator lane plus its slice of the output register.
module fifo_rd_packer_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  cap,
  input  logic                  ld,
  input  logic                  keep,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] lane_q
);
  logic [DATA_WIDTH-1:0] acc_q;

  // Capture the returning FIFO entry when this lane is the write target.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (cap) acc_q <= din;
  end

  // Output slice: the entry landing this edge bypasses the accumulator so a
  // word can close on the same edge that captures its final lane.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)  lane_q <= '0;
    else if (ld) lane_q <= keep ? (cap ? din : acc_q) : '0;
  end
endmodule

module fifo_rd_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             rd_clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_last
);
  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam logic [CW:0]   PR_OCC    = (CW+1)'(PACK_RATIO);
  localparam logic [CW-1:0] PR_CNT    = CW'(PACK_RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_RATIO - 1);

  typedef struct packed {
    logic [PACK_RATIO-1:0] keep;
    logic                  last;
  } ctl_t;

  // Elaboration-time parameter sanity.
  if (PACK_RATIO < 2 || PACK_RATIO > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fifo_rd_packer: PACK_RATIO must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  logic [CW-1:0] cnt;
  logic          rd_pend;
  logic          flush_req;
  logic          arm;
  logic          out_vld;
  ctl_t          out_ctl;
  ctl_t          ld_ctl;

  logic          out_free;
  logic [CW:0]   occ;
  logic          load_full;
  logic          load_part;
  logic          load;
  logic          timeout_hit;

  logic [PACK_RATIO-1:0]                 cap;
  logic [PACK_RATIO-1:0]                 part_keep;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] out_lanes;

  // Close/load decisions and the read strobe.
  always_comb begin
    out_free  = ~out_vld | out_ready;
    occ       = {1'b0, cnt} + {{CW{1'b0}}, rd_pend};
    load_full = out_free & ((rd_pend & (cnt == LAST_LANE)) | (cnt == PR_CNT));
    load_part = out_free & flush_req & ~rd_pend & (cnt != '0) & ~load_full;
    load      = load_full | load_part;
    ld_ctl.keep = load_full ? {PACK_RATIO{1'b1}} : part_keep;
    ld_ctl.last = load_full ? (flush_req | flush | timeout_hit) : 1'b1;
    // A word retiring this edge frees lane 0, so read ahead into the next
    // word to keep the stream bubble-free.
    fifo_rd_en = arm & ~fifo_empty & ~flush_req & ((occ < PR_OCC) | load_full);
  end

  for (genvar i = 0; i < PACK_RATIO; i++) begin : g_lane
    assign cap[i]       = rd_pend & (cnt == CW'(i));
    assign part_keep[i] = (CW'(i) < cnt);
    fifo_rd_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .rd_clk (rd_clk),
      .rst_n  (rst_n),
      .cap    (cap[i]),
      .ld     (load),
      .keep   (ld_ctl.keep[i]),
      .din    (fifo_rd_data),
      .lane_q (out_lanes[i])
    );
  end

`ifdef FIFO_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          idle;

  assign idle        = (cnt != '0) & ~rd_pend & fifo_empty;
  assign timeout_hit = idle & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs while a partial word starves, restarts on any activity.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)                          idle_cnt <= '0;
    else if (rd_pend | load | timeout_hit) idle_cnt <= '0;
    else if (idle)                       idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Read pipeline and the no-read-on-first-cycle-after-reset guard.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      arm     <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en;
      arm     <= 1'b1;
    end
  end

  // Lane count: resets on any word load, otherwise advances per capture.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (load)    cnt <= '0;
    else if (rd_pend) cnt <= cnt + 1'b1;
  end

  // Flush request: consumed by a word load, or dropped when nothing is held.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)                                 flush_req <= 1'b0;
    else if (load_full)                         flush_req <= 1'b0;
    else if (load_part)                         flush_req <= flush;
    else if (flush | timeout_hit)               flush_req <= 1'b1;
    else if (flush_req & (cnt == '0) & ~rd_pend) flush_req <= 1'b0;
  end

  // Output register control: load takes priority over a transfer.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_ctl <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_ctl <= ld_ctl;
    end else if (out_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign out_valid = out_vld;
  assign out_keep  = out_ctl.keep;
  assign out_last  = out_ctl.last;
  assign out_data  = out_lanes;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4).
// A behavioural FIFO with 1-cycle read latency feeds the DUT; a vector table
// covers full and flushed words, hand sequences cover stall, flush corners,
// timeout and mid-flight reset. Honours FIFO_PACK_TIMEOUT_EN if defined.
module tb_fifo_rd_packer;
  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  logic [7:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  int rd_count = 0;
  int rd_viol = 0;

  always #5 rd_clk = ~rd_clk;
  assign fifo_empty = (wp == rp);

  fifo_rd_packer dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last)
  );

  // FIFO model: read data appears the edge after an accepted read.
  always @(posedge rd_clk) begin
    if (fifo_rd_en && fifo_empty) rd_viol <= rd_viol + 1;
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[rp[7:0]];
      rp           <= rp + 1;
      rd_count     <= rd_count + 1;
    end
  end

  task automatic step();
    @(negedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wp[7:0]] = d;
    wp = wp + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int lim, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < lim) begin
      step();
      cyc++;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic chk_word(input string name, input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"},  out_data, d);
    chk({name, "_keep"},  {28'd0, out_keep}, {28'd0, k});
    chk({name, "_last"},  {31'd0, out_last}, {31'd0, l});
  endtask

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic            do_flush;
    logic [31:0]     exp_data;
    logic [3:0]      exp_keep;
    logic            exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int  cyc;
    int  rc0;
    bit  seen;

    vecs[0] = '{n:3'd4, d:32'h44332211, do_flush:1'b0, exp_data:32'h44332211, exp_keep:4'hF, exp_last:1'b0};
    vecs[1] = '{n:3'd4, d:32'hEFBEADDE, do_flush:1'b0, exp_data:32'hEFBEADDE, exp_keep:4'hF, exp_last:1'b0};
    vecs[2] = '{n:3'd2, d:32'h0000BBAA, do_flush:1'b1, exp_data:32'h0000BBAA, exp_keep:4'h3, exp_last:1'b1};
    vecs[3] = '{n:3'd1, d:32'h0000005A, do_flush:1'b1, exp_data:32'h0000005A, exp_keep:4'h1, exp_last:1'b1};
    vecs[4] = '{n:3'd3, d:32'h00030201, do_flush:1'b1, exp_data:32'h00030201, exp_keep:4'h7, exp_last:1'b1};
    vecs[5] = '{n:3'd4, d:32'hFF00FF00, do_flush:1'b0, exp_data:32'hFF00FF00, exp_keep:4'hF, exp_last:1'b0};

    // Reset state, then idle with an empty FIFO.
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_keep",  {28'd0, out_keep}, 32'd0);
    chk("rst_last",  {31'd0, out_last}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (fifo_rd_en || out_valid) seen = 1'b1;
    end
    chk("idle_empty_activity", {31'd0, seen}, 32'd0);
    chk("idle_data", out_data, 32'd0);

    // First-word latency: valid 5 cycles after the first read strobe.
    out_ready = 1'b1;
    step();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk("lat_first_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    wait_valid(20, cyc);
    chk("lat_cycles", cyc, 32'd5);
    chk_word("lat_word", 32'h44332211, 4'hF, 1'b0);
    step();
    chk("lat_valid_drop", {31'd0, out_valid}, 32'd0);

    // Vector table: full words and flushed partial words.
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < int'(vecs[v].n); j++) push(vecs[v].d[j]);
      if (vecs[v].do_flush) begin
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
          step();
          if (out_valid) seen = 1'b1;
        end
        chk($sformatf("vec%0d_no_early", v), {31'd0, seen}, 32'd0);
        pulse_flush();
      end
      wait_valid(20, cyc);
      chk_word($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last);
      step();
    end

    // Backpressure: first word holds, second waits in the accumulator.
    out_ready = 1'b0;
    rc0 = rd_count;
    for (int j = 1; j <= 9; j++) push(8'(j));
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) chk("stall_data_c10", out_data, 32'h04030201);
    end
    chk_word("stall_word1", 32'h04030201, 4'hF, 1'b0);
    chk("stall_reads", rd_count - rc0, 32'd8);
    out_ready = 1'b1;
    step();
    chk_word("stall_word2", 32'h08070605, 4'hF, 1'b0);
    step();
    repeat (8) step();
    pulse_flush();
    wait_valid(20, cyc);
    chk_word("stall_tail", 32'h00000009, 4'h1, 1'b1);
    step();

    // Flush with nothing held produces no output.
    pulse_flush();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("flush_empty_no_out", {31'd0, seen}, 32'd0);

    // Flush on the edge that captures the final lane.
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_word("flush_final_lane", 32'hA4A3A2A1, 4'hF, 1'b1);
    step();
    chk("flush_final_drop", {31'd0, out_valid}, 32'd0);

    // Flush while a full word waits behind a stalled output.
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) push(8'(8'h10 + j));
    repeat (15) step();
    chk_word("wait_w1", 32'h13121110, 4'hF, 1'b0);
    pulse_flush();
    repeat (3) step();
    out_ready = 1'b1;
    step();
    chk_word("wait_w2_flushed", 32'h17161514, 4'hF, 1'b1);
    step();
    repeat (4) step();
    chk("wait_drained", {31'd0, out_valid}, 32'd0);

    // Single entry then idle: timeout flush or indefinite hold.
    push(8'h5A);
`ifdef FIFO_PACK_TIMEOUT_EN
    wait_valid(40, cyc);
    chk_word("timeout_word", 32'h0000005A, 4'h1, 1'b1);
    step();
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("no_timeout_hold", {31'd0, seen}, 32'd0);
    pulse_flush();
    wait_valid(20, cyc);
    chk_word("no_timeout_flush", 32'h0000005A, 4'h1, 1'b1);
    step();
`endif

    // Reset with a word valid, cnt=2 and a read in flight.
    out_ready = 1'b0;
    step();
    for (int j = 1; j <= 7; j++) push(8'(8'hB0 + j));
    repeat (7) step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",  out_data, 32'd0);
    chk("mid_rst_keep",  {28'd0, out_keep}, 32'd0);
    chk("mid_rst_last",  {31'd0, out_last}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    step();
    step();
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_rd", {31'd0, fifo_rd_en}, 32'd0);
    step();
    chk("post_rst_rd", {31'd0, fifo_rd_en}, 32'd1);
    wait_valid(20, cyc);
    chk_word("post_rst_word", 32'hC4C3C2C1, 4'hF, 1'b0);
    step();

    chk("rd_while_empty", rd_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
